// File: rtl/sumador_serie.sv
// Digit-serial unsigned adder: adds DIGIT bits per clock over WIDTH/DIGIT cycles
// and publishes {carry_out, sum} once, with a one-cycle done pulse.
module sumador_serie #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("sumador_serie: WIDTH must be at least 2");
  end
  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("sumador_serie: DIGIT must divide WIDTH exactly");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   sum_q, sum_d;

  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] res_shift;
  logic             accept;
  logic             last;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from registers, so no input reaches an output combinationally
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    sum  = sum_q;
  end

  // Datapath: one digit per RUN cycle, the partial result enters from the top
  always_comb begin
    accept    = start && (state_q != RUN);
    last      = (state_q == RUN) && (cnt_q == LAST);
    digit_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry_q};
    res_shift = (res_q >> DIGIT)
              | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;

    if (accept) begin
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      cnt_d   = '0;
      res_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      carry_d = digit_sum[DIGIT];
      res_d   = res_shift;
      cnt_d   = cnt_q + CNT_W'(1);
    end

    if (last) begin
      sum_d = {digit_sum[DIGIT], res_shift};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: tb/tb_sumador_serie.sv
// Directed and random checks of sumador_serie across several WIDTH/DIGIT pairs.
module tb_sumador_serie;

  logic        clk;
  logic        rst;
  logic [5:0]  start_v;
  logic [5:0]  cin_v;
  logic [15:0] a_v [6];
  logic [15:0] b_v [6];
  logic [5:0]  busy_v;
  logic [5:0]  done_v;
  logic [16:0] sum_v [6];

  logic [4:0]  s0;
  logic [8:0]  s1, s2, s3, s4;
  logic [16:0] s5;

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: W4/D1  1: W8/D2  2: W8/D4  3: W8/D8  4: W8/D1  5: W16/D4
  sumador_serie #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0][3:0]), .b(b_v[0][3:0]),
    .cin(cin_v[0]), .busy(busy_v[0]), .done(done_v[0]), .sum(s0));
  sumador_serie #(.WIDTH(8), .DIGIT(2)) u_w8d2 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1][7:0]), .b(b_v[1][7:0]),
    .cin(cin_v[1]), .busy(busy_v[1]), .done(done_v[1]), .sum(s1));
  sumador_serie #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2][7:0]), .b(b_v[2][7:0]),
    .cin(cin_v[2]), .busy(busy_v[2]), .done(done_v[2]), .sum(s2));
  sumador_serie #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
    .clk(clk), .rst(rst), .start(start_v[3]), .a(a_v[3][7:0]), .b(b_v[3][7:0]),
    .cin(cin_v[3]), .busy(busy_v[3]), .done(done_v[3]), .sum(s3));
  sumador_serie #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst(rst), .start(start_v[4]), .a(a_v[4][7:0]), .b(b_v[4][7:0]),
    .cin(cin_v[4]), .busy(busy_v[4]), .done(done_v[4]), .sum(s4));
  sumador_serie #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
    .clk(clk), .rst(rst), .start(start_v[5]), .a(a_v[5]), .b(b_v[5]),
    .cin(cin_v[5]), .busy(busy_v[5]), .done(done_v[5]), .sum(s5));

  always_comb begin
    sum_v[0] = {12'b0, s0};
    sum_v[1] = {8'b0, s1};
    sum_v[2] = {8'b0, s2};
    sum_v[3] = {8'b0, s3};
    sum_v[4] = {8'b0, s4};
    sum_v[5] = s5;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts an addition at the current negedge, scrambles the inputs after capture,
  // then counts busy cycles until the done cycle (or the bound runs out).
  task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                        input logic c, output logic [16:0] s, output int cycles,
                        output logic held, output logic dn);
    logic [16:0] prev;
    prev         = sum_v[sel];
    a_v[sel]     = a;
    b_v[sel]     = b;
    cin_v[sel]   = c;
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    a_v[sel]     = ~a;
    b_v[sel]     = ~b;
    cin_v[sel]   = ~c;
    cycles = 0;
    held   = 1'b1;
    while (busy_v[sel] && cycles < 64) begin
      cycles++;
      if (sum_v[sel] !== prev) held = 1'b0;
      @(negedge clk);
    end
    s  = sum_v[sel];
    dn = done_v[sel];
  endtask

  task automatic op_check(input string tag, input int sel, input logic [15:0] a,
                          input logic [15:0] b, input logic c,
                          input logic [16:0] exp, input int exp_cyc);
    logic [16:0] s;
    int          cyc;
    logic        held, dn;
    run_op(sel, a, b, c, s, cyc, held, dn);
    check({tag, "_busy_cycles"}, cyc, exp_cyc);
    check({tag, "_done"}, dn, 1'b1);
    check({tag, "_sum"}, s, exp);
    check({tag, "_sum_held"}, held, 1'b1);
  endtask

  initial begin
    logic [16:0] s, e;
    logic [15:0] ra, rb, mask;
    logic        rc, held, dn;
    int          cyc, pulses, w;
    int          sels [3];

    rst     = 1'b1;
    start_v = '0;
    cin_v   = '0;
    for (int i = 0; i < 6; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end

    // Reset state, and start ignored while rst is high
    #1;
    check("rst_busy", {26'b0, busy_v}, 32'h0);
    check("rst_done", {26'b0, done_v}, 32'h0);
    check("rst_sum0", sum_v[0], 17'h0);
    check("rst_sum5", sum_v[5], 17'h0);
    a_v[0] = 16'h3;
    b_v[0] = 16'h3;
    start_v[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("start_during_rst", busy_v[0], 1'b0);
    start_v[0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_rst", busy_v[0], 1'b0);

    // Basic W4/D1 additions
    op_check("w4_2p3", 0, 16'h2, 16'h3, 1'b0, 17'h05, 4);
    @(negedge clk);
    check("w4_done_one_cycle", done_v[0], 1'b0);
    check("w4_idle_busy", busy_v[0], 1'b0);
    check("w4_idle_sum_hold", sum_v[0], 17'h05);
    op_check("w4_c_plus_a", 0, 16'hC, 16'hA, 1'b0, 17'h16, 4);
    @(negedge clk);
    op_check("w4_full_carry", 0, 16'hF, 16'hF, 1'b1, 17'h1F, 4);
    @(negedge clk);

    // 0xFF + 0x01 at several digit widths
    op_check("w8d2_ff01", 1, 16'hFF, 16'h01, 1'b0, 17'h100, 4);
    op_check("w8d4_ff01", 2, 16'hFF, 16'h01, 1'b0, 17'h100, 2);
    op_check("w8d8_ff01", 3, 16'hFF, 16'h01, 1'b0, 17'h100, 1);
    @(negedge clk);
    check("w8d8_done_one_cycle", done_v[3], 1'b0);

    // Start ignored while running: second request in the 2nd RUN cycle
    a_v[0] = 16'h3;
    b_v[0] = 16'h4;
    cin_v[0] = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("ign_busy", busy_v[0], 1'b1);
      if (i == 1) begin
        a_v[0] = 16'h9;
        b_v[0] = 16'h9;
        start_v[0] = 1'b1;
      end
      if (i == 2) start_v[0] = 1'b0;
      @(negedge clk);
    end
    check("ign_done", done_v[0], 1'b1);
    check("ign_sum", sum_v[0], 17'h07);
    @(negedge clk);
    check("ign_no_second_done", done_v[0], 1'b0);
    check("ign_busy_not_extended", busy_v[0], 1'b0);

    // Back-to-back: second start lands in the DONE cycle of the first
    op_check("b2b_first", 0, 16'h1, 16'h1, 1'b0, 17'h02, 4);
    op_check("b2b_second", 0, 16'h5, 16'h6, 1'b1, 17'h0C, 4);
    @(negedge clk);

    // Reset asserted between edges in the 2nd RUN cycle
    a_v[0] = 16'h7;
    b_v[0] = 16'h8;
    cin_v[0] = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", busy_v[0], 1'b0);
    check("midrst_sum", sum_v[0], 17'h0);
    check("midrst_done", done_v[0], 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_v[0]) pulses++;
    end
    check("midrst_no_done", pulses, 0);
    check("midrst_sum_stays0", sum_v[0], 17'h0);
    op_check("after_rst", 0, 16'h2, 16'h3, 1'b0, 17'h05, 4);
    @(negedge clk);

    // Random additions, back-to-back
    sels[0] = 4;
    sels[1] = 1;
    sels[2] = 5;
    for (int k = 0; k < 3; k++) begin
      w    = (sels[k] == 5) ? 16 : 8;
      mask = (w == 16) ? 16'hFFFF : 16'h00FF;
      repeat (200) begin
        ra = 16'($urandom) & mask;
        rb = 16'($urandom) & mask;
        rc = 1'($urandom);
        e  = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
        run_op(sels[k], ra, rb, rc, s, cyc, held, dn);
        check("rand_done", dn, 1'b1);
        check("rand_sum", s, e);
        if (s !== e || dn !== 1'b1) begin
          $fatal(1, "random addition wrong on instance %0d: %0h + %0h + %0h", sels[k], ra, rb, rc);
        end
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
